rx_seq_checker: RTL and testbench

- Receive-side companion of the SiTCP-XG test generator. It snoops the SiTCP-XG RX buffer write port and verifies that the byte stream from the PC is an incrementing 8-bit counter, mod 256.
- It counts received bytes and mismatches, and owns RX_RADR, RX_SIZE and RX_CLR_REQ so the RX buffer is released as soon as bytes are checked.
- It is used when the generator is not in loopback and no other block reads the RX buffer.

---
 rtl/rx_seq_checker.sv | 210 +++++++++++++++++++++
 tb/tb_rx_seq_checker.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/rx_seq_checker.sv
// Snoops the SiTCP-XG RX buffer write port and checks the byte stream is an incrementing mod-256
// counter. Optional first-error capture is enabled by defining RX_CHK_ERR_CAPTURE_EN.
module rx_seq_checker #(
    parameter int unsigned CNT_W       = 64,
    parameter int unsigned ERR_W       = 32,
    parameter int unsigned RX_SIZE_VAL = 4000,
    parameter int unsigned ADR_W       = 12
) (
    input  logic             CLK156M,
    input  logic             RSTs_N,
    input  logic             CHK_CLR,
    input  logic             SiTCPXG_ESTABLISHED,
    input  logic [15:0]      SiTCPXG_RX_WADR,
    input  logic [7:0]       SiTCPXG_RX_WENB,
    input  logic [63:0]      SiTCPXG_RX_WDAT,
    input  logic             SiTCPXG_RX_CLR_ENB,
    output logic             SiTCPXG_RX_CLR_REQ,
    output logic [15:0]      SiTCPXG_RX_RADR,
    output logic [15:0]      SiTCPXG_RX_SIZE,
    output logic [CNT_W-1:0] RX_BYTE_CNT,
    output logic [ERR_W-1:0] ERR_CNT,
    output logic             ERR_FLAG,
    output logic [CNT_W-1:0] FIRST_ERR_POS,
    output logic [7:0]       FIRST_ERR_EXP,
    output logic [7:0]       FIRST_ERR_ACT
);

    localparam logic [15:0] ADR_MASK = 16'((32'd1 << ADR_W) - 32'd1);

    assign SiTCPXG_RX_CLR_REQ = SiTCPXG_RX_CLR_ENB;
    assign SiTCPXG_RX_SIZE    = 16'(RX_SIZE_VAL);

    // S0: input capture
    logic        s0_valid_q, s0_est_q;
    logic [12:0] s0_base_q;
    logic [7:0]  s0_wenb_q;
    logic [63:0] s0_wdat_q;

    always_ff @(posedge CLK156M) begin
        if (!RSTs_N) begin
            s0_valid_q <= 1'b0;
            s0_est_q   <= 1'b0;
            s0_base_q  <= '0;
            s0_wenb_q  <= '0;
            s0_wdat_q  <= '0;
        end else begin
            s0_valid_q <= (SiTCPXG_RX_WENB != 8'h00) && !SiTCPXG_RX_CLR_ENB;
            s0_est_q   <= SiTCPXG_ESTABLISHED;
            s0_base_q  <= SiTCPXG_RX_WADR[15:3];
            s0_wenb_q  <= SiTCPXG_RX_WENB;
            s0_wdat_q  <= SiTCPXG_RX_WDAT;
        end
    end

    // S1: lane chain, lane 7 holds the lowest address
    logic        seeded_q;
    logic [7:0]  prev_q;
    logic [7:0]  ref_byte;
    logic        have_ref;
    logic [3:0]  lane_cnt, lane_err;
    logic [2:0]  last_off;
`ifdef RX_CHK_ERR_CAPTURE_EN
    logic        found;
    logic [3:0]  f_idx;
    logic [7:0]  f_exp, f_act;
`endif

    always_comb begin
        ref_byte = prev_q;
        have_ref = seeded_q;
        lane_cnt = '0;
        lane_err = '0;
        last_off = '0;
`ifdef RX_CHK_ERR_CAPTURE_EN
        found = 1'b0;
        f_idx = '0;
        f_exp = '0;
        f_act = '0;
`endif
        for (int lane = 7; lane >= 0; lane--) begin
            if (s0_wenb_q[lane]) begin
                if (have_ref && (s0_wdat_q[lane*8 +: 8] != 8'(ref_byte + 8'd1))) begin
                    lane_err = lane_err + 4'd1;
`ifdef RX_CHK_ERR_CAPTURE_EN
                    if (!found) begin
                        found = 1'b1;
                        f_idx = lane_cnt;
                        f_exp = 8'(ref_byte + 8'd1);
                        f_act = s0_wdat_q[lane*8 +: 8];
                    end
`endif
                end
                // Resync: the next reference is what actually arrived.
                ref_byte = s0_wdat_q[lane*8 +: 8];
                have_ref = 1'b1;
                lane_cnt = lane_cnt + 4'd1;
                last_off = 3'(7 - lane);
            end
        end
    end

    logic        s1_valid_q;
    logic [3:0]  s1_cnt_q, s1_err_q;
    logic [12:0] s1_base_q;
    logic [2:0]  s1_last_off_q;
`ifdef RX_CHK_ERR_CAPTURE_EN
    logic [3:0]  s1_f_idx_q;
    logic [7:0]  s1_f_exp_q, s1_f_act_q;
`endif

    always_ff @(posedge CLK156M) begin
        if (!RSTs_N) begin
            s1_valid_q    <= 1'b0;
            seeded_q      <= 1'b0;
            prev_q        <= '0;
            s1_cnt_q      <= '0;
            s1_err_q      <= '0;
            s1_base_q     <= '0;
            s1_last_off_q <= '0;
`ifdef RX_CHK_ERR_CAPTURE_EN
            s1_f_idx_q    <= '0;
            s1_f_exp_q    <= '0;
            s1_f_act_q    <= '0;
`endif
        end else begin
            s1_valid_q <= s0_valid_q && s0_est_q && !SiTCPXG_RX_CLR_ENB && !CHK_CLR;
            if (SiTCPXG_RX_CLR_ENB || CHK_CLR || !s0_est_q) begin
                seeded_q <= 1'b0;
            end else if (s0_valid_q) begin
                seeded_q <= 1'b1;
                prev_q   <= ref_byte;
            end
            s1_cnt_q      <= lane_cnt;
            s1_err_q      <= lane_err;
            s1_base_q     <= s0_base_q;
            s1_last_off_q <= last_off;
`ifdef RX_CHK_ERR_CAPTURE_EN
            s1_f_idx_q    <= f_idx;
            s1_f_exp_q    <= f_exp;
            s1_f_act_q    <= f_act;
`endif
        end
    end

    // S2: counters and read pointer
    logic [CNT_W-1:0] byte_cnt_q;
    logic [ERR_W-1:0] err_cnt_q;
    logic             err_flag_q;
    logic [15:0]      radr_q;
    logic [ERR_W:0]   err_sum;
    logic [15:0]      radr_next;

    assign err_sum   = {1'b0, err_cnt_q} + {{(ERR_W-3){1'b0}}, s1_err_q};
    assign radr_next = ({s1_base_q, 3'b000} + 16'(s1_last_off_q) + 16'd1) & ADR_MASK;

    always_ff @(posedge CLK156M) begin
        if (!RSTs_N) begin
            byte_cnt_q <= '0;
            err_cnt_q  <= '0;
            err_flag_q <= 1'b0;
            radr_q     <= '0;
        end else begin
            if (CHK_CLR) begin
                byte_cnt_q <= '0;
                err_cnt_q  <= '0;
                err_flag_q <= 1'b0;
            end else if (s1_valid_q) begin
                byte_cnt_q <= byte_cnt_q + {{(CNT_W-4){1'b0}}, s1_cnt_q};
                err_cnt_q  <= err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
                if (s1_err_q != 4'd0) err_flag_q <= 1'b1;
            end
            if (SiTCPXG_RX_CLR_ENB) begin
                radr_q <= SiTCPXG_RX_WADR & ADR_MASK;
            end else if (s1_valid_q && !CHK_CLR) begin
                radr_q <= radr_next;
            end
        end
    end

`ifdef RX_CHK_ERR_CAPTURE_EN
    logic [CNT_W-1:0] f_pos_q;
    logic [7:0]       f_exp_q, f_act_q;

    always_ff @(posedge CLK156M) begin
        if (!RSTs_N || CHK_CLR) begin
            f_pos_q <= '0;
            f_exp_q <= '0;
            f_act_q <= '0;
        end else if (s1_valid_q && !err_flag_q && (s1_err_q != 4'd0)) begin
            f_pos_q <= byte_cnt_q + {{(CNT_W-4){1'b0}}, s1_f_idx_q};
            f_exp_q <= s1_f_exp_q;
            f_act_q <= s1_f_act_q;
        end
    end

    assign FIRST_ERR_POS = f_pos_q;
    assign FIRST_ERR_EXP = f_exp_q;
    assign FIRST_ERR_ACT = f_act_q;
`else
    assign FIRST_ERR_POS = '0;
    assign FIRST_ERR_EXP = '0;
    assign FIRST_ERR_ACT = '0;
`endif

    assign RX_BYTE_CNT     = byte_cnt_q;
    assign ERR_CNT         = err_cnt_q;
    assign ERR_FLAG        = err_flag_q;
    assign SiTCPXG_RX_RADR = radr_q;

endmodule

// File: tb/tb_rx_seq_checker.sv
// Directed self-checking bench for rx_seq_checker; expectations follow RX_CHK_ERR_CAPTURE_EN.
`timescale 1ns/1ps
module tb_rx_seq_checker;

`ifdef RX_CHK_ERR_CAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, chk_clr, est, clr_enb;
    logic [15:0] wadr;
    logic [7:0]  wenb;
    logic [63:0] wdat;
    logic        clr_req;
    logic [15:0] radr, rx_size;
    logic [63:0] byte_cnt, f_pos;
    logic [31:0] err_cnt;
    logic        err_flag;
    logic [7:0]  f_exp, f_act;

    int checks = 0;
    int errors = 0;

    always #3 clk = ~clk;

    rx_seq_checker dut (
        .CLK156M             (clk),
        .RSTs_N              (rst_n),
        .CHK_CLR             (chk_clr),
        .SiTCPXG_ESTABLISHED (est),
        .SiTCPXG_RX_WADR     (wadr),
        .SiTCPXG_RX_WENB     (wenb),
        .SiTCPXG_RX_WDAT     (wdat),
        .SiTCPXG_RX_CLR_ENB  (clr_enb),
        .SiTCPXG_RX_CLR_REQ  (clr_req),
        .SiTCPXG_RX_RADR     (radr),
        .SiTCPXG_RX_SIZE     (rx_size),
        .RX_BYTE_CNT         (byte_cnt),
        .ERR_CNT             (err_cnt),
        .ERR_FLAG            (err_flag),
        .FIRST_ERR_POS       (f_pos),
        .FIRST_ERR_EXP       (f_exp),
        .FIRST_ERR_ACT       (f_act)
    );

    task automatic write_word(input logic [15:0] a, input logic [7:0] e, input logic [63:0] d);
        wadr = a;
        wenb = e;
        wdat = d;
        @(posedge clk); #1;
        wenb = 8'h00;
    endtask

    task automatic idle(input int n);
        wenb = 8'h00;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_chk_clr();
        chk_clr = 1'b1;
        @(posedge clk); #1;
        chk_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; chk_clr = 1'b0; est = 1'b0; clr_enb = 1'b0;
        wadr = '0; wenb = '0; wdat = '0;
        idle(3);
        checks++; if (byte_cnt !== 64'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", byte_cnt); end
        checks++; if (err_cnt !== 32'd0) begin errors++; $display("FAIL reset_err got %0d exp 0", err_cnt); end
        checks++; if (err_flag !== 1'b0) begin errors++; $display("FAIL reset_flag got %b exp 0", err_flag); end
        checks++; if (radr !== 16'h0) begin errors++; $display("FAIL reset_radr got %h exp 0", radr); end
        checks++; if (rx_size !== 16'd4000) begin errors++; $display("FAIL rx_size got %0d exp 4000", rx_size); end
        checks++; if (clr_req !== 1'b0) begin errors++; $display("FAIL reset_clr_req got %b exp 0", clr_req); end
        checks++; if (f_pos !== 64'd0) begin errors++; $display("FAIL reset_fpos got %0d exp 0", f_pos); end
        rst_n = 1'b1;
        est = 1'b1;
        idle(1);
    endtask

    task automatic test_seeded();
        pulse_chk_clr();
        write_word(16'h0000, 8'hFF, 64'h0102030405060708);
        write_word(16'h0008, 8'hFF, 64'h090A0B0C0D0E0F10);
        idle(1);
        checks++; if (byte_cnt !== 64'd8) begin errors++; $display("FAIL seeded_lat_cnt got %0d exp 8", byte_cnt); end
        checks++; if (radr !== 16'h0008) begin errors++; $display("FAIL seeded_lat_radr got %h exp 0008", radr); end
        idle(1);
        checks++; if (byte_cnt !== 64'd16) begin errors++; $display("FAIL seeded_cnt got %0d exp 16", byte_cnt); end
        checks++; if (err_cnt !== 32'd0) begin errors++; $display("FAIL seeded_err got %0d exp 0", err_cnt); end
        checks++; if (radr !== 16'h0010) begin errors++; $display("FAIL seeded_radr got %h exp 0010", radr); end
        checks++; if (err_flag !== 1'b0) begin errors++; $display("FAIL seeded_flag got %b exp 0", err_flag); end
    endtask

    task automatic test_partial();
        pulse_chk_clr();
        write_word(16'h0003, 8'h1F, 64'h000000FEFF000102);
        write_word(16'h0008, 8'hE0, 64'h0304050000000000);
        idle(2);
        checks++; if (byte_cnt !== 64'd8) begin errors++; $display("FAIL partial_cnt got %0d exp 8", byte_cnt); end
        checks++; if (err_cnt !== 32'd0) begin errors++; $display("FAIL partial_err got %0d exp 0", err_cnt); end
        checks++; if (radr !== 16'h000B) begin errors++; $display("FAIL partial_radr got %h exp 000b", radr); end
    endtask

    task automatic test_noncontig();
        pulse_chk_clr();
        write_word(16'h0010, 8'hA5, 64'h10AA11BBCC12DD13);
        idle(2);
        checks++; if (byte_cnt !== 64'd4) begin errors++; $display("FAIL noncontig_cnt got %0d exp 4", byte_cnt); end
        checks++; if (err_cnt !== 32'd0) begin errors++; $display("FAIL noncontig_err got %0d exp 0", err_cnt); end
        checks++; if (radr !== 16'h0018) begin errors++; $display("FAIL noncontig_radr got %h exp 0018", radr); end
    endtask

    task automatic test_corrupt();
        pulse_chk_clr();
        write_word(16'h0020, 8'hFF, 64'h0102030405660708);
        write_word(16'h0028, 8'hFF, 64'h090A0B0C0D0E0F10);
        idle(2);
        checks++; if (err_cnt !== 32'd2) begin errors++; $display("FAIL corrupt_err got %0d exp 2", err_cnt); end
        checks++; if (err_flag !== 1'b1) begin errors++; $display("FAIL corrupt_flag got %b exp 1", err_flag); end
        checks++; if (byte_cnt !== 64'd16) begin errors++; $display("FAIL corrupt_cnt got %0d exp 16", byte_cnt); end
        checks++; if (radr !== 16'h0030) begin errors++; $display("FAIL corrupt_radr got %h exp 0030", radr); end
        checks++; if (f_pos !== (CAP ? 64'd5 : 64'd0)) begin errors++; $display("FAIL corrupt_fpos got %0d exp %0d", f_pos, CAP ? 5 : 0); end
        checks++; if (f_exp !== (CAP ? 8'h06 : 8'h00)) begin errors++; $display("FAIL corrupt_fexp got %h exp %h", f_exp, CAP ? 8'h06 : 8'h00); end
        checks++; if (f_act !== (CAP ? 8'h66 : 8'h00)) begin errors++; $display("FAIL corrupt_fact got %h exp %h", f_act, CAP ? 8'h66 : 8'h00); end
        // Expected 0x11 next; 0x50 is a later error that must not move the capture.
        write_word(16'h0030, 8'h80, 64'h5000000000000000);
        idle(2);
        checks++; if (err_cnt !== 32'd3) begin errors++; $display("FAIL later_err got %0d exp 3", err_cnt); end
        checks++; if (f_pos !== (CAP ? 64'd5 : 64'd0)) begin errors++; $display("FAIL later_fpos got %0d exp %0d", f_pos, CAP ? 5 : 0); end
        checks++; if (f_act !== (CAP ? 8'h66 : 8'h00)) begin errors++; $display("FAIL later_fact got %h exp %h", f_act, CAP ? 8'h66 : 8'h00); end
    endtask

    task automatic test_chk_clr_midstream();
        write_word(16'h0038, 8'hFF, 64'hAA02030405060708);
        write_word(16'h0040, 8'hFF, 64'h090A0B0C0D0E0F10);
        chk_clr = 1'b1;
        @(posedge clk); #1;
        chk_clr = 1'b0;
        checks++; if (byte_cnt !== 64'd0) begin errors++; $display("FAIL chkclr_cnt got %0d exp 0", byte_cnt); end
        checks++; if (err_cnt !== 32'd0) begin errors++; $display("FAIL chkclr_err got %0d exp 0", err_cnt); end
        checks++; if (err_flag !== 1'b0) begin errors++; $display("FAIL chkclr_flag got %b exp 0", err_flag); end
        checks++; if (f_pos !== 64'd0) begin errors++; $display("FAIL chkclr_fpos got %0d exp 0", f_pos); end
        idle(3);
        checks++; if (byte_cnt !== 64'd0) begin errors++; $display("FAIL chkclr_flush_cnt got %0d exp 0", byte_cnt); end
        checks++; if (radr !== 16'h0031) begin errors++; $display("FAIL chkclr_flush_radr got %h exp 0031", radr); end
        write_word(16'h0048, 8'h80, 64'h9900000000000000);
        idle(2);
        checks++; if (byte_cnt !== 64'd1) begin errors++; $display("FAIL chkclr_seed_cnt got %0d exp 1", byte_cnt); end
        checks++; if (err_cnt !== 32'd0) begin errors++; $display("FAIL chkclr_seed_err got %0d exp 0", err_cnt); end
        checks++; if (radr !== 16'h0049) begin errors++; $display("FAIL chkclr_seed_radr got %h exp 0049", radr); end
    endtask

    task automatic test_dropped();
        pulse_chk_clr();
        write_word(16'h0000, 8'hF0, 64'h0102040500000000);
        idle(2);
        checks++; if (err_cnt !== 32'd1) begin errors++; $display("FAIL dropped_err got %0d exp 1", err_cnt); end
        checks++; if (byte_cnt !== 64'd4) begin errors++; $display("FAIL dropped_cnt got %0d exp 4", byte_cnt); end
        checks++; if (radr !== 16'h0004) begin errors++; $display("FAIL dropped_radr got %h exp 0004", radr); end
    endtask

    task automatic test_clear();
        clr_enb = 1'b1;
        wadr = 16'h07F8;
        wenb = 8'h00;
        #1;
        checks++; if (clr_req !== 1'b1) begin errors++; $display("FAIL clear_req got %b exp 1", clr_req); end
        @(posedge clk); #1;
        clr_enb = 1'b0;
        #1;
        checks++; if (clr_req !== 1'b0) begin errors++; $display("FAIL clear_req_low got %b exp 0", clr_req); end
        checks++; if (radr !== 16'h07F8) begin errors++; $display("FAIL clear_radr got %h exp 07f8", radr); end
        write_word(16'h07F8, 8'h80, 64'h5500000000000000);
        idle(2);
        checks++; if (err_cnt !== 32'd1) begin errors++; $display("FAIL clear_seed_err got %0d exp 1", err_cnt); end
        checks++; if (byte_cnt !== 64'd5) begin errors++; $display("FAIL clear_seed_cnt got %0d exp 5", byte_cnt); end
        checks++; if (radr !== 16'h07F9) begin errors++; $display("FAIL clear_seed_radr got %h exp 07f9", radr); end
    endtask

    task automatic test_established();
        est = 1'b0;
        write_word(16'h0100, 8'hFF, 64'h1111111111111111);
        idle(2);
        checks++; if (byte_cnt !== 64'd5) begin errors++; $display("FAIL est_hold_cnt got %0d exp 5", byte_cnt); end
        checks++; if (radr !== 16'h07F9) begin errors++; $display("FAIL est_hold_radr got %h exp 07f9", radr); end
        est = 1'b1;
        write_word(16'h0108, 8'h80, 64'h7700000000000000);
        idle(2);
        checks++; if (err_cnt !== 32'd1) begin errors++; $display("FAIL est_seed_err got %0d exp 1", err_cnt); end
        checks++; if (byte_cnt !== 64'd6) begin errors++; $display("FAIL est_seed_cnt got %0d exp 6", byte_cnt); end
        checks++; if (radr !== 16'h0109) begin errors++; $display("FAIL est_seed_radr got %h exp 0109", radr); end
    endtask

    task automatic test_wrap();
        // Last lane of the top word: read pointer wraps to 0 under the address mask.
        write_word(16'hFFF8, 8'h01, 64'h0000000000000078);
        idle(2);
        checks++; if (radr !== 16'h0000) begin errors++; $display("FAIL wrap_radr got %h exp 0000", radr); end
        checks++; if (err_cnt !== 32'd1) begin errors++; $display("FAIL wrap_err got %0d exp 1", err_cnt); end
        checks++; if (byte_cnt !== 64'd7) begin errors++; $display("FAIL wrap_cnt got %0d exp 7", byte_cnt); end
    endtask

    task automatic test_reset_end();
        write_word(16'h0000, 8'hFF, 64'h0102030405060708);
        idle(2);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++; if (byte_cnt !== 64'd0) begin errors++; $display("FAIL rst_end_cnt got %0d exp 0", byte_cnt); end
        checks++; if (err_cnt !== 32'd0) begin errors++; $display("FAIL rst_end_err got %0d exp 0", err_cnt); end
        checks++; if (err_flag !== 1'b0) begin errors++; $display("FAIL rst_end_flag got %b exp 0", err_flag); end
        checks++; if (radr !== 16'h0000) begin errors++; $display("FAIL rst_end_radr got %h exp 0000", radr); end
        checks++; if (f_act !== 8'h00) begin errors++; $display("FAIL rst_end_fact got %h exp 00", f_act); end
    endtask

    initial begin
        test_reset();
        test_seeded();
        test_partial();
        test_noncontig();
        test_corrupt();
        test_chk_clr_midstream();
        test_dropped();
        test_clear();
        test_established();
        test_wrap();
        test_reset_end();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
